// File: rtl/hack_pkg.sv
// Shared constants for the Hack CPU: instruction field positions,
// the default address width and the stall state encoding.
package hack_pkg;

    localparam int INSTR_TYPE = 15;
    localparam int A_BIT      = 12;
    localparam int CMP_HI     = 11;
    localparam int CMP_LO     = 6;

    localparam int DEST_A = 5;
    localparam int DEST_D = 4;
    localparam int DEST_M = 3;

    localparam int JLT = 2;
    localparam int JEQ = 1;
    localparam int JGT = 0;

    localparam int ADDR_WIDTH = 15;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/ALU.sv
// Hack ALU: 16-bit combinational stage with zx/nx/zy/ny/f/no control.
// f selects a full 16-bit add (carry dropped) or a bitwise 16-bit AND.
module ALU (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic        zx,
    input  logic        nx,
    input  logic        zy,
    input  logic        ny,
    input  logic        f,
    input  logic        no,
    output logic [15:0] out,
    output logic        zr,
    output logic        ng
);

    logic [15:0] x_z, x_n, y_z, y_n, res;

    // operand conditioning, function select, optional output negate
    always_comb begin
        x_z = zx ? 16'h0000 : x;
        x_n = nx ? ~x_z : x_z;
        y_z = zy ? 16'h0000 : y;
        y_n = ny ? ~y_z : y_z;
        res = f ? (x_n + y_n) : (x_n & y_n);
        out = no ? ~res : res;
        zr  = (out == 16'h0000);
        ng  = out[15];
    end

endmodule

// File: rtl/hack_cpu.sv
// Single-cycle Hack CPU: decode, A/D/PC registers, jump resolution and a
// RUN/WAIT stall machine that holds all architectural state while the data
// RAM is busy with the current M access.
//
// state | meaning
// RUN   | previous cycle committed an instruction
// WAIT  | previous cycle was stalled on mem_ready; registers held
module hack_cpu
    import hack_pkg::*;
#(
    parameter int ADDR_WIDTH = hack_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           instruction,
    input  logic [15:0]           inM,
    input  logic                  mem_ready,
    output logic [15:0]           outM,
    output logic                  writeM,
    output logic [ADDR_WIDTH-1:0] addressM,
    output logic [ADDR_WIDTH-1:0] pc
);

    logic [15:0]           a_reg;
    logic [15:0]           d_reg;
    logic [ADDR_WIDTH-1:0] pc_reg;
    state_t                state;

    logic        is_c, sel_m, d1, d2, d3, j1, j2, j3;
    logic [15:0] alu_y, alu_out;
    logic        alu_zr, alu_ng;
    logic        access, stall, jump;

    // instruction decode, memory access and jump resolution
    always_comb begin
        is_c   = instruction[INSTR_TYPE];
        sel_m  = instruction[A_BIT];
        d1     = instruction[DEST_A];
        d2     = instruction[DEST_D];
        d3     = instruction[DEST_M];
        j1     = instruction[JLT];
        j2     = instruction[JEQ];
        j3     = instruction[JGT];
        alu_y  = sel_m ? inM : a_reg;
        access = is_c & (sel_m | d3);
        stall  = access & ~mem_ready;
        jump   = is_c & ((j1 & alu_ng) | (j2 & alu_zr) | (j3 & ~alu_ng & ~alu_zr));
    end

    ALU u_alu (
        .x   (d_reg),
        .y   (alu_y),
        .zx  (instruction[CMP_HI]),
        .nx  (instruction[CMP_HI-1]),
        .zy  (instruction[CMP_HI-2]),
        .ny  (instruction[CMP_HI-3]),
        .f   (instruction[CMP_HI-4]),
        .no  (instruction[CMP_LO]),
        .out (alu_out),
        .zr  (alu_zr),
        .ng  (alu_ng)
    );

    assign outM     = alu_out;
    assign writeM   = is_c & d3 & rst_n;
    assign addressM = a_reg[ADDR_WIDTH-1:0];
    assign pc       = pc_reg;

    // register commit; a stall holds A, D and PC so the M access repeats unchanged
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg  <= '0;
            d_reg  <= '0;
            pc_reg <= '0;
            state  <= RUN;
        end else if (stall) begin
            state <= WAIT;
        end else begin
            state <= RUN;
            if (is_c) begin
                if (d1) a_reg <= alu_out;
                if (d2) d_reg <= alu_out;
            end else begin
                a_reg <= instruction;
            end
            pc_reg <= jump ? a_reg[ADDR_WIDTH-1:0] : pc_reg + ADDR_WIDTH'(1);
        end
    end

    // state is debug-only; the C-type filler bits and upper A bits have no function
    logic unused_ok;
    assign unused_ok = ^{instruction[14:13], a_reg, state};

endmodule
